// File: rtl/cus19_pkg.sv
// Shared constants and FSM state type for the CUS19 fetch stage.
package cus19_pkg;

  localparam logic [18:0] CUS19_NOP      = 19'h0;
  localparam int unsigned CUS19_RESET_PC = 0;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_REDIR = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/cus19_fetch_skid.sv
// One-entry {instr,pc} holding buffer for a fetch response that arrives while decode is stalled.
module cus19_fetch_skid
  import cus19_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_in,
  input  logic                   pop_in,
  input  logic                   flush_in,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  output logic                   full_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  pc_out
);

  logic                   full_q, full_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;

  // Push wins over pop so a simultaneous drain-and-refill keeps the newer entry.
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_in) begin
      full_d  = 1'b0;
      instr_d = INSTR_WIDTH'(CUS19_NOP);
    end else if (push_in) begin
      full_d  = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end else if (pop_in) begin
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= INSTR_WIDTH'(CUS19_NOP);
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full_out  = full_q;
  assign instr_out = instr_q;
  assign pc_out    = pc_q;

endmodule

// File: rtl/cus19_fetch_unit.sv
// CUS19 IF stage: owns the PC, issues synchronous imem reads and loads the IF/ID register,
// with stall skid buffering and taken-branch redirect/flush.
module cus19_fetch_unit
  import cus19_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH  = 8,
  parameter int unsigned          INSTR_WIDTH = 19,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(CUS19_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_in,
  input  logic                   branch_in,
  input  logic [ADDR_WIDTH-1:0]  branch_target_in,
  output logic                   imem_en_out,
  output logic [ADDR_WIDTH-1:0]  imem_addr_out,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_in,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic                   valid_out
);

  fetch_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   tag_vld_q, tag_vld_d;
  logic [ADDR_WIDTH-1:0]  tag_pc_q, tag_pc_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_WIDTH-1:0]  ifid_pc_q, ifid_pc_d;
  logic                   ifid_valid_q, ifid_valid_d;

  logic                   issue;
  logic                   skid_push, skid_pop, skid_flush, skid_full;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [ADDR_WIDTH-1:0]  skid_pc;

  cus19_fetch_skid #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push_in   (skid_push),
    .pop_in    (skid_pop),
    .flush_in  (skid_flush),
    .instr_in  (imem_rdata_in),
    .pc_in     (tag_pc_q),
    .full_out  (skid_full),
    .instr_out (skid_instr),
    .pc_out    (skid_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tag_vld_d    = 1'b0;
    tag_pc_d     = tag_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    issue        = 1'b0;
    skid_push    = 1'b0;
    skid_pop     = 1'b0;
    skid_flush   = 1'b0;

    unique case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (branch_in) state_d = S_REDIR;
               else if (stall_in) state_d = S_STALL;
      S_STALL: if (branch_in) state_d = S_REDIR;
               else if (!stall_in) state_d = S_RUN;
      S_REDIR: if (branch_in) state_d = S_REDIR;
               else if (stall_in) state_d = S_STALL;
               else state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase

    // Taken branch drops the in-flight response (tag not renewed) and the skid.
    if (branch_in) begin
      pc_d         = branch_target_in;
      ifid_valid_d = 1'b0;
      ifid_instr_d = INSTR_WIDTH'(CUS19_NOP);
      skid_flush   = 1'b1;
    end else begin
      // Issue is also allowed from S_STALL on the release cycle when the skid is empty.
      issue = (state_q != S_BOOT) && !stall_in && !skid_full;
      if (issue) begin
        tag_vld_d = 1'b1;
        tag_pc_d  = pc_q;
        pc_d      = pc_q + ADDR_WIDTH'(1);
      end
      skid_push = tag_vld_q && (stall_in || skid_full);
      if (!stall_in) begin
        if (skid_full) begin
          skid_pop     = 1'b1;
          ifid_instr_d = skid_instr;
          ifid_pc_d    = skid_pc;
          ifid_valid_d = 1'b1;
        end else if (tag_vld_q) begin
          ifid_instr_d = imem_rdata_in;
          ifid_pc_d    = tag_pc_q;
          ifid_valid_d = 1'b1;
        end else begin
          ifid_instr_d = INSTR_WIDTH'(CUS19_NOP);
          ifid_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      tag_vld_q    <= 1'b0;
      tag_pc_q     <= '0;
      ifid_instr_q <= INSTR_WIDTH'(CUS19_NOP);
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tag_vld_q    <= tag_vld_d;
      tag_pc_q     <= tag_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_en_out   = issue;
  assign imem_addr_out = pc_q;
  assign instr_out     = ifid_instr_q;
  assign pc_out        = ifid_pc_q;
  assign valid_out     = ifid_valid_q;

endmodule

// File: tb/tb_cus19_fetch_unit.sv
// Self-checking bench for cus19_fetch_unit: directed scenarios plus a randomized run
// checked against a program-order model of the fetch stream.
module tb_cus19_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        branch_in;
  logic [7:0]  branch_target_in;
  logic        imem_en_out;
  logic [7:0]  imem_addr_out;
  logic [18:0] imem_rdata_in = '0;
  logic [18:0] instr_out;
  logic [7:0]  pc_out;
  logic        valid_out;

  logic [18:0] mem [256];
  int checks = 0;
  int errors = 0;

  cus19_fetch_unit #(
    .ADDR_WIDTH  (8),
    .INSTR_WIDTH (19),
    .RESET_PC    (8'd0)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_in         (stall_in),
    .branch_in        (branch_in),
    .branch_target_in (branch_target_in),
    .imem_en_out      (imem_en_out),
    .imem_addr_out    (imem_addr_out),
    .imem_rdata_in    (imem_rdata_in),
    .instr_out        (instr_out),
    .pc_out           (pc_out),
    .valid_out        (valid_out)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data for the address issued last cycle.
  always @(posedge clk) if (imem_en_out) imem_rdata_in <= mem[imem_addr_out];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < 256; i++)
      mem[i] = rnd ? 19'($urandom) : 19'(i + 'h100);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_in = 1'b0; branch_in = 1'b0; branch_target_in = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_in = 1'b0; branch_in = 1'b0; branch_target_in = '0;
    #12;
    checks++;
    if ({imem_en_out, imem_addr_out, instr_out, pc_out, valid_out} !== '0) begin
      errors++;
      $display("FAIL reset_values: got en=%b addr=%h instr=%h pc=%h v=%b expected all 0",
               imem_en_out, imem_addr_out, instr_out, pc_out, valid_out);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      tick();
      checks++;
      if (valid_out !== 1'b0) begin
        errors++; $display("FAIL boot_valid_edge%0d: got %b expected 0", e, valid_out);
      end
    end
    tick();
    checks++;
    if ({valid_out, pc_out, instr_out} !== {1'b1, 8'd0, mem[0]}) begin
      errors++;
      $display("FAIL first_valid: got v=%b pc=%h instr=%h expected v=1 pc=00 instr=%h",
               valid_out, pc_out, instr_out, mem[0]);
    end
  endtask

  task automatic test_stream();
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++;
      if ({valid_out, pc_out, instr_out} !== {1'b1, 8'(k), mem[k]}) begin
        errors++;
        $display("FAIL stream: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 valid_out, pc_out, instr_out, 8'(k), mem[k]);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] seen [$];
    do_reset();
    for (int i = 0; i < 20; i++) begin if (valid_out && pc_out == 8'd4) break; tick(); end
    stall_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({valid_out, pc_out, instr_out, imem_en_out} !== {1'b1, 8'd4, mem[4], 1'b0}) begin
        errors++;
        $display("FAIL stall_hold: got v=%b pc=%h instr=%h en=%b expected v=1 pc=04 instr=%h en=0",
                 valid_out, pc_out, instr_out, imem_en_out, mem[4]);
      end
    end
    stall_in = 1'b0;
    #1;
    checks++;
    if (imem_en_out !== 1'b0) begin
      errors++; $display("FAIL release_no_issue_with_skid: got en=%b expected 0", imem_en_out);
    end
    tick();
    checks++;
    if ({valid_out, pc_out, instr_out} !== {1'b1, 8'd5, mem[5]}) begin
      errors++;
      $display("FAIL skid_drain: got v=%b pc=%h expected v=1 pc=05", valid_out, pc_out);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid_out) seen.push_back(pc_out);
    end
    checks++;
    if (seen.size() < 2 || seen[0] !== 8'd6 || seen[1] !== 8'd7) begin
      errors++;
      $display("FAIL stall_order: got %0d valid pcs first=%h expected 06 then 07",
               seen.size(), (seen.size() > 0) ? seen[0] : 8'hxx);
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 20; i++) begin if (valid_out && pc_out == 8'd10) break; tick(); end
    branch_in = 1'b1; branch_target_in = 8'h40;
    tick();
    branch_in = 1'b0;
    checks++;
    if ({valid_out, instr_out} !== '0) begin
      errors++; $display("FAIL branch_flush1: got v=%b instr=%h expected 0 0", valid_out, instr_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL branch_flush2: got v=%b expected 0", valid_out);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({valid_out, pc_out, instr_out} !== {1'b1, 8'(8'h40 + k), mem[8'h40 + k]}) begin
        errors++;
        $display("FAIL branch_target: got v=%b pc=%h expected v=1 pc=%h",
                 valid_out, pc_out, 8'(8'h40 + k));
      end
    end
  endtask

  task automatic test_branch_stall();
    do_reset();
    for (int i = 0; i < 20; i++) begin if (valid_out && pc_out == 8'd3) break; tick(); end
    stall_in = 1'b1;
    tick(); tick();
    branch_in = 1'b1; branch_target_in = 8'h80;
    tick();
    branch_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL branch_stall_flush: got v=%b expected 0", valid_out);
    end
    tick();
    stall_in = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (valid_out) break; end
    checks++;
    if ({valid_out, pc_out, instr_out} !== {1'b1, 8'h80, mem[8'h80]}) begin
      errors++;
      $display("FAIL branch_stall_first: got v=%b pc=%h expected v=1 pc=80", valid_out, pc_out);
    end
    for (int i = 0; i < 4; i++) begin tick(); if (valid_out) break; end
    checks++;
    if ({valid_out, pc_out} !== {1'b1, 8'h81}) begin
      errors++;
      $display("FAIL branch_stall_next: got v=%b pc=%h expected v=1 pc=81", valid_out, pc_out);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    do_reset();
    tick();
    branch_in = 1'b1; branch_target_in = 8'hFE;
    tick();
    branch_in = 1'b0;
    tick();
    exp = 8'hFE;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({valid_out, pc_out, instr_out} !== {1'b1, exp, mem[exp]}) begin
        errors++;
        $display("FAIL wrap: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 valid_out, pc_out, instr_out, exp, mem[exp]);
      end
      exp = exp + 8'd1;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 20; i++) begin if (valid_out && pc_out == 8'd5) break; tick(); end
    stall_in = 1'b1;
    tick(); tick();
    branch_in = 1'b1; branch_target_in = 8'h33;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({imem_en_out, imem_addr_out, instr_out, pc_out, valid_out} !== '0) begin
      errors++;
      $display("FAIL mid_reset_values: got addr=%h instr=%h pc=%h v=%b expected all 0",
               imem_addr_out, instr_out, pc_out, valid_out);
    end
    branch_in = 1'b0; stall_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({valid_out, pc_out, instr_out} !== {1'b1, 8'd0, mem[0]}) begin
      errors++;
      $display("FAIL mid_reset_restart: got v=%b pc=%h expected v=1 pc=00", valid_out, pc_out);
    end
  endtask

  // Model: valid instructions appear in program order from the latest branch target;
  // stalls freeze IF/ID, a branch blanks it for two edges.
  task automatic test_random();
    logic [7:0]  exp_pc, tgt;
    logic [27:0] prev;
    bit st, br, stalled_since;
    int since_br, bubbles;
    fill_mem(1'b1);
    do_reset();
    exp_pc = 8'd0; since_br = 100; stalled_since = 1'b0; bubbles = 0;
    for (int n = 0; n < 400; n++) begin
      st  = ($urandom_range(0, 99) < 25);
      br  = ($urandom_range(0, 99) < 8);
      tgt = 8'($urandom);
      prev = {valid_out, pc_out, instr_out};
      stall_in = st; branch_in = br; branch_target_in = tgt;
      tick();
      since_br++;
      if (st) stalled_since = 1'b1;
      if (br) begin
        exp_pc = tgt; since_br = 0; stalled_since = 1'b0; bubbles = 0;
        checks++;
        if ({valid_out, instr_out} !== '0) begin
          errors++; $display("FAIL rnd_branch_blank: got v=%b instr=%h expected 0 0", valid_out, instr_out);
        end
      end else if (st) begin
        bubbles = 0;
        checks++;
        if ({valid_out, pc_out, instr_out} !== prev) begin
          errors++; $display("FAIL rnd_stall_hold: got %h expected %h", {valid_out, pc_out, instr_out}, prev);
        end
      end else if (valid_out) begin
        bubbles = 0;
        checks++;
        if ({pc_out, instr_out} !== {exp_pc, mem[exp_pc]} || since_br == 1) begin
          errors++;
          $display("FAIL rnd_order: got pc=%h instr=%h expected pc=%h instr=%h (edges since branch %0d)",
                   pc_out, instr_out, exp_pc, mem[exp_pc], since_br);
        end
        exp_pc = exp_pc + 8'd1;
      end else begin
        bubbles++;
        checks++;
        if (instr_out !== '0 || bubbles > 3 || (since_br == 2 && !stalled_since)) begin
          errors++;
          $display("FAIL rnd_bubble: got instr=%h bubbles=%0d since_branch=%0d expected NOP and progress",
                   instr_out, bubbles, since_br);
        end
      end
    end
    stall_in = 1'b0; branch_in = 1'b0;
  endtask

  initial begin
    fill_mem(1'b0);
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
